// File: rtl/dfd_debug_lane_align_trainer.sv
// Lane-skew trainer: timestamps a marker's arrival on each raw lane, then derives per-lane
// 2-bit delay selects that align every lane to the latest one. DFD_CLA_LANE_ALIGN_CLAMP_EN clamps excess skew instead of erroring.
module dfd_debug_lane_align_trainer #(
  parameter int unsigned DEBUG_MUX_OUTPUT_WIDTH = 64,
  parameter int unsigned LANE_WIDTH             = 8,
  parameter int unsigned NUM_OUTPUT_LANES       = DEBUG_MUX_OUTPUT_WIDTH / LANE_WIDTH,
  parameter logic [LANE_WIDTH-1:0] MARKER       = LANE_WIDTH'(8'hA5),
  parameter int unsigned TIMEOUT                = 255,
  parameter int unsigned MAX_SKEW               = 3
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [DEBUG_MUX_OUTPUT_WIDTH-1:0] debug_signals_in,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [NUM_OUTPUT_LANES*2-1:0]   mux_sel,
  output logic [NUM_OUTPUT_LANES*8-1:0]   arrival_dbg
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
  ,
  output logic                            clamp_flag
`endif
);

  localparam int unsigned NL = NUM_OUTPUT_LANES;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_error_nxt;
  logic [CW-1:0]       r_cnt;
  logic [NL-1:0]       r_seen;
  logic [CW-1:0]       r_arrival [NL];
  logic [NL*2-1:0]     r_mux_sel;
  logic [NL-1:0]       w_match;
  logic [NL-1:0]       w_hit;
  logic                w_all_seen;
  logic                w_start_acc;
  logic [CW-1:0]       w_max;
  logic [CW-1:0]       w_diff [NL];
  logic [NL-1:0]       w_over;
  logic [NL*2-1:0]     w_sel;
  logic                w_skew_ok;

  genvar g;
  generate
    for (g = 0; g < NL; g++) begin : g_lane
      assign w_match[g] = (debug_signals_in[g*LANE_WIDTH +: LANE_WIDTH] == MARKER);
      assign w_diff[g]  = w_max - r_arrival[g];
      assign w_over[g]  = (w_diff[g] > CW'(MAX_SKEW));
      // Excess skew saturates at the largest encodable select.
      assign w_sel[2*g +: 2]      = w_over[g] ? 2'd3 : w_diff[g][1:0];
      assign arrival_dbg[8*g +: 8] = 8'(r_arrival[g]);
    end
  endgenerate

  assign w_hit       = w_match & ~r_seen;
  assign w_all_seen  = &(r_seen | w_match);
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
  assign w_skew_ok = 1'b1;
`else
  assign w_skew_ok = ~|w_over;
`endif

  // Latest arrival among all lanes is the alignment target.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < int'(NL); i++) begin
      if (r_arrival[i] > w_max) w_max = r_arrival[i];
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_state_nxt = S_WAIT;
      S_WAIT: begin
        // All-seen wins over a coincident timeout.
        if (w_all_seen)                  w_state_nxt = S_COMPUTE;
        else if (r_cnt == CW'(TIMEOUT))  w_state_nxt = S_ERR;
      end
      S_COMPUTE: w_state_nxt = w_skew_ok ? S_DONE : S_ERR;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    case (w_state_nxt)
      S_WAIT, S_COMPUTE: w_busy_nxt  = 1'b1;
      S_DONE:            w_done_nxt  = 1'b1;
      S_ERR:             w_error_nxt = 1'b1;
      default:           w_busy_nxt  = 1'b0;
    endcase
  end

  // Arrival capture, cycle counter and select update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_seen    <= '0;
      r_mux_sel <= '0;
      for (int i = 0; i < int'(NL); i++) r_arrival[i] <= '0;
    end else begin
      if (w_start_acc) begin
        r_cnt  <= '0;
        r_seen <= '0;
      end else if (r_state == S_WAIT) begin
        if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + CW'(1);
        r_seen <= r_seen | w_hit;
        for (int i = 0; i < int'(NL); i++) begin
          if (w_hit[i]) r_arrival[i] <= r_cnt;
        end
      end
      if ((r_state == S_COMPUTE) && w_skew_ok) r_mux_sel <= w_sel;
    end
  end

`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
  logic r_clamp;

  // Sticky record that some lane needed more delay than the select can encode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  r_clamp <= 1'b0;
    else if (w_start_acc)          r_clamp <= 1'b0;
    else if (r_state == S_COMPUTE) r_clamp <= r_clamp | (|w_over);
  end

  assign clamp_flag = r_clamp;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign mux_sel = r_mux_sel;

endmodule

// File: tb/tb_dfd_debug_lane_align_trainer.sv
// Randomized bench for dfd_debug_lane_align_trainer against an arrival-time reference model.
// Build with DFD_CLA_LANE_ALIGN_CLAMP_EN defined to exercise the clamping variant.
module tb_dfd_debug_lane_align_trainer;

  localparam int NL = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] din = '0;
  logic        busy, done, error;
  logic [15:0] mux_sel;
  logic [63:0] arrival_dbg;
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
  logic        clamp_flag;
`endif

  dfd_debug_lane_align_trainer dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .debug_signals_in (din),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .mux_sel          (mux_sel),
    .arrival_dbg      (arrival_dbg)
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
    ,
    .clamp_flag       (clamp_flag)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state carried across runs.
  logic [15:0] m_mux;
  int          m_arr [NL];
  logic        m_clamp;

  // Per-run stimulus: first-marker cycle per lane (-1 = never) and one optional repeat marker.
  int t_arr [NL];
  int t_dup_lane;
  int t_dup_at;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] noise();
    logic [7:0] v;
    do v = 8'($urandom); while (v == 8'hA5);
    return v;
  endfunction

  function automatic logic [63:0] exp_arr_pack();
    logic [63:0] p;
    for (int i = 0; i < NL; i++) p[8*i +: 8] = 8'(m_arr[i]);
    return p;
  endfunction

  task automatic run_train(input string tag);
    bit          never, over, exp_done, exp_err, exp_clamp;
    int          mx, d, exp_end, got_end;
    logic [15:0] new_mux, exp_mux;
    never = 0; over = 0; mx = 0; new_mux = '0;
    for (int i = 0; i < NL; i++) begin
      if (t_arr[i] < 0) never = 1;
      else if (t_arr[i] > mx) mx = t_arr[i];
    end
    exp_mux = m_mux; exp_clamp = 0; exp_done = 0; exp_err = 0;
    if (never) begin
      exp_end = 256;
      exp_err = 1;
    end else begin
      exp_end = mx + 2;
      for (int i = 0; i < NL; i++) begin
        d = mx - t_arr[i];
        if (d > 3) over = 1;
        new_mux[2*i +: 2] = (d > 3) ? 2'd3 : 2'(d);
      end
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
      exp_done = 1; exp_mux = new_mux; exp_clamp = over;
`else
      if (over) exp_err = 1;
      else begin exp_done = 1; exp_mux = new_mux; end
`endif
    end
    for (int i = 0; i < NL; i++) if (t_arr[i] >= 0 && t_arr[i] <= 255) m_arr[i] = t_arr[i];
    m_mux = exp_mux; m_clamp = exp_clamp;

    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < NL; i++) din[8*i +: 8] = noise();
    @(negedge clock);
    start = 1'b0;
    got_end = -1;
    for (int k = 0; k < 300; k++) begin
      if (k == 0) begin
        check({tag, ":busy_start"}, 64'(busy), 64'd1);
        check({tag, ":done_clr"}, 64'(done), 64'd0);
        check({tag, ":err_clr"}, 64'(error), 64'd0);
      end
      if (done || error) begin got_end = k; break; end
      for (int i = 0; i < NL; i++)
        din[8*i +: 8] = (k == t_arr[i] || (i == t_dup_lane && k == t_dup_at)) ? 8'hA5 : noise();
      @(negedge clock);
    end
    check({tag, ":latency"}, 64'(got_end), 64'(exp_end));
    check({tag, ":done"}, 64'(done), 64'(exp_done));
    check({tag, ":error"}, 64'(error), 64'(exp_err));
    check({tag, ":busy_end"}, 64'(busy), 64'd0);
    check({tag, ":mux_sel"}, 64'(mux_sel), 64'(exp_mux));
    check({tag, ":arrival"}, arrival_dbg, exp_arr_pack());
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
    check({tag, ":clamp"}, 64'(clamp_flag), 64'(exp_clamp));
`endif
    // Status must hold while idle.
    repeat (3) @(negedge clock);
    check({tag, ":hold_mux"}, 64'(mux_sel), 64'(exp_mux));
    check({tag, ":hold_lvl"}, {62'd0, done, error}, {62'd0, exp_done, exp_err});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":error"}, 64'(error), 64'd0);
    check({tag, ":mux_sel"}, 64'(mux_sel), 64'd0);
    check({tag, ":arrival"}, arrival_dbg, 64'd0);
`ifdef DFD_CLA_LANE_ALIGN_CLAMP_EN
    check({tag, ":clamp"}, 64'(clamp_flag), 64'd0);
`endif
  endtask

  initial begin
    m_mux = '0; m_clamp = 1'b0;
    for (int i = 0; i < NL; i++) m_arr[i] = 0;
    t_dup_lane = -1; t_dup_at = -1;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    t_arr = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_train("aligned");
    t_arr = '{4, 5, 6, 7, 4, 5, 6, 7};
    run_train("staircase");
    check("staircase:pattern", 64'(mux_sel), 64'h1B1B);
    t_arr = '{2, 2, 2, -1, 2, 2, 2, 2};
    run_train("lane3_missing");
    t_arr = '{2, 7, 7, 7, 7, 7, 7, 7};
    run_train("skew5");
    t_arr = '{6, 6, 3, 6, 6, 6, 6, 6};
    t_dup_lane = 2; t_dup_at = 6;
    run_train("first_wins");
    t_dup_lane = -1; t_dup_at = -1;

    // Reset in the middle of WAIT.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t_arr = '{0, 1, -1, -1, -1, -1, -1, -1};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NL; i++) din[8*i +: 8] = (k == t_arr[i]) ? 8'hA5 : noise();
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    m_mux = '0; m_clamp = 1'b0;
    for (int i = 0; i < NL; i++) m_arr[i] = 0;
    t_arr = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_train("after_reset");

    for (int r = 0; r < 24; r++) begin
      int base;
      base = int'($urandom_range(0, 20));
      for (int i = 0; i < NL; i++) t_arr[i] = base + int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) t_arr[$urandom_range(0, 7)] = base + int'($urandom_range(4, 6));
      if ($urandom_range(0, 7) == 0) t_arr[$urandom_range(0, 7)] = -1;
      t_dup_lane = int'($urandom_range(0, 7));
      if (t_arr[t_dup_lane] >= 0) t_dup_at = t_arr[t_dup_lane] + int'($urandom_range(1, 5));
      else begin t_dup_lane = -1; t_dup_at = -1; end
      run_train($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
